// File: rtl/el2_ifu_halfword_aligner.sv
// Halfword aligner: buffers fetch words as halfwords and presents whole instructions at the head.
// Compressed (16-bit) instruction support is enabled by defining RV_ALIGN_COMPRESSED_EN.
module el2_ifu_halfword_aligner (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    input  logic        fetch_hw_offset,
    output logic        fetch_ready,
    output logic        i0_valid,
    output logic [31:0] i0_instr,
    output logic        i0_is_c,
    input  logic        i0_ready
);

    logic [15:0] hw_mem [4];
    logic [1:0]  rptr;
    logic [1:0]  wptr;
    logic [2:0]  count;

    logic [15:0] head_hw;
    logic [15:0] next_hw;
    logic        head_c;
    logic        wr_two;
    logic        push;
    logic [15:0] wr_hw0;
    logic [2:0]  push_n;
    logic [2:0]  pop_n;

    assign head_hw = hw_mem[rptr];
    assign next_hw = hw_mem[rptr + 2'd1];

`ifdef RV_ALIGN_COMPRESSED_EN
    assign head_c = (head_hw[1:0] != 2'b11);
    assign wr_two = !fetch_hw_offset;
`else
    // Every head is 32-bit and the upper-half-only offset is meaningless.
    logic unused_hw_offset;
    assign unused_hw_offset = fetch_hw_offset;
    assign head_c = 1'b0;
    assign wr_two = 1'b1;
`endif

    always_comb begin
        fetch_ready = !flush && (count <= 3'd2);
        i0_valid    = !flush && (((count >= 3'd1) && head_c) ||
                                 ((count >= 3'd2) && !head_c));
        i0_is_c     = i0_valid && head_c;
        i0_instr    = '0;
        if (i0_valid) begin
            i0_instr = head_c ? {16'h0000, head_hw} : {next_hw, head_hw};
        end
        push   = fetch_valid && fetch_ready;
        wr_hw0 = wr_two ? fetch_data[15:0] : fetch_data[31:16];
        push_n = '0;
        if (push) begin
            push_n = wr_two ? 3'd2 : 3'd1;
        end
        pop_n = '0;
        if (i0_valid && i0_ready) begin
            pop_n = head_c ? 3'd1 : 3'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else if (flush) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            count <= count + push_n - pop_n;
            rptr  <= rptr + pop_n[1:0];
            wptr  <= wptr + push_n[1:0];
        end
    end

    // Storage is unreset; entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            hw_mem[wptr] <= wr_hw0;
            if (wr_two) begin
                hw_mem[wptr + 2'd1] <= fetch_data[31:16];
            end
        end
    end

endmodule

// File: tb/tb_el2_ifu_halfword_aligner.sv
// Randomized and directed bench for el2_ifu_halfword_aligner against a halfword-queue model.
// Follows RV_ALIGN_COMPRESSED_EN so the model matches the build under test.
module tb_el2_ifu_halfword_aligner;

`ifdef RV_ALIGN_COMPRESSED_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_hw_offset = 1'b0;
    logic        fetch_ready;
    logic        i0_valid;
    logic [31:0] i0_instr;
    logic        i0_is_c;
    logic        i0_ready = 1'b0;

    el2_ifu_halfword_aligner dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .fetch_hw_offset (fetch_hw_offset),
        .fetch_ready     (fetch_ready),
        .i0_valid        (i0_valid),
        .i0_instr        (i0_instr),
        .i0_is_c         (i0_is_c),
        .i0_ready        (i0_ready)
    );

    always #5 clk = ~clk;

    logic [15:0] q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_is_c;
    logic [31:0] exp_instr;
    logic        exp_is32;
    logic [34:0] exp_vec;

    // Expected outputs follow directly from what halfwords are queued.
    task automatic compute_exp();
        int cnt;
        cnt = q.size();
        exp_is32 = 1'b1;
        if (cnt > 0) exp_is32 = !COMP || (q[0][1:0] == 2'b11);
        exp_ready = !flush && (cnt <= 2);
        exp_valid = !flush && ((cnt >= 1 && !exp_is32) || (cnt >= 2 && exp_is32));
        exp_is_c  = exp_valid && !exp_is32;
        exp_instr = '0;
        if (exp_valid) begin
            if (exp_is32) exp_instr = {q[1], q[0]};
            else          exp_instr = {16'h0000, q[0]};
        end
        exp_vec = {exp_ready, exp_valid, exp_is_c, exp_instr};
    endtask

    task automatic drive(input logic fv, input logic [31:0] d, input logic off,
                         input logic rdy, input logic fl);
        @(negedge clk);
        fetch_valid     = fv;
        fetch_data      = d;
        fetch_hw_offset = off;
        i0_ready        = rdy;
        flush           = fl;
        #1;
        compute_exp();
    endtask

    task automatic commit();
        @(posedge clk);
        if (!rst) begin
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && i0_ready) begin
                    repeat (exp_is32 ? 2 : 1) void'(q.pop_front());
                end
                if (fetch_valid && exp_ready) begin
                    if (COMP && fetch_hw_offset) begin
                        q.push_back(fetch_data[31:16]);
                    end else begin
                        q.push_back(fetch_data[15:0]);
                        q.push_back(fetch_data[31:16]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        q.delete();
        compute_exp();
        n_cmp++;
        if ({fetch_ready, i0_valid, i0_is_c, i0_instr} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state got=%h expected=%h",
                     {fetch_ready, i0_valid, i0_is_c, i0_instr}, {1'b1, 1'b0, 1'b0, 32'h0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string name, input logic [35:0] tbl[$]);
        foreach (tbl[i]) begin
            drive(tbl[i][35], tbl[i][34:3], tbl[i][2], tbl[i][1], tbl[i][0]);
            n_cmp++;
            if ({fetch_ready, i0_valid, i0_is_c, i0_instr} !== exp_vec) begin
                n_bad++;
                $display("FAIL %s step%0d got=%h expected=%h", name, i,
                         {fetch_ready, i0_valid, i0_is_c, i0_instr}, exp_vec);
            end
            commit();
        end
    endtask

    // Table rows: {fetch_valid, fetch_data, fetch_hw_offset, i0_ready, flush}
    task automatic test_compressed_pair();
        drive(1'b1, 32'h00130001, 1'b0, 1'b0, 1'b0);
        commit();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (i0_instr !== (COMP ? 32'h00000001 : 32'h00130001) || i0_is_c !== COMP) begin
            n_bad++;
            $display("FAIL pair_head got=%h/%b expected=%h/%b", i0_instr, i0_is_c,
                     COMP ? 32'h00000001 : 32'h00130001, COMP);
        end
        commit();
        run_table("pair", '{{1'b0, 32'h0, 1'b0, 1'b0, 1'b0},
                            {1'b0, 32'h0, 1'b0, 1'b1, 1'b1},
                            {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}});
    endtask

    task automatic test_full_word();
        run_table("full_word", '{{1'b1, 32'h00A00093, 1'b0, 1'b1, 1'b0},
                                 {1'b0, 32'h0, 1'b0, 1'b1, 1'b0},
                                 {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}});
    endtask

    task automatic test_split();
        run_table("split", '{{1'b1, 32'h00934501, 1'b0, 1'b1, 1'b0},
                             {1'b1, 32'h12340013, 1'b0, 1'b1, 1'b0},
                             {1'b0, 32'h0, 1'b0, 1'b1, 1'b0},
                             {1'b0, 32'h0, 1'b0, 1'b1, 1'b0},
                             {1'b0, 32'h0, 1'b0, 1'b1, 1'b0},
                             {1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
                             {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}});
    endtask

    task automatic test_backpressure();
        logic [35:0] tbl[$];
        for (int i = 0; i < 3; i++) tbl.push_back({1'b1, $urandom(), 1'b0, 1'b0, 1'b0});
        run_table("bp_fill", tbl);
        drive(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full_ready got=%b expected=0", fetch_ready);
        end
        commit();
        tbl.delete();
        for (int i = 0; i < 6; i++) tbl.push_back({1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        tbl.push_back({1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
        run_table("bp_drain", tbl);
    endtask

    task automatic test_flush();
        run_table("flush_fill", '{{1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0},
                                  {1'b1, 32'h0005ABCD, 1'b1, 1'b0, 1'b0},
                                  {1'b1, 32'h77778888, 1'b0, 1'b1, 1'b1}});
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({fetch_ready, i0_valid, i0_instr} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL flush_after got=%h expected=%h",
                     {fetch_ready, i0_valid, i0_instr}, {1'b1, 1'b0, 32'h0});
        end
        commit();
    endtask

    task automatic test_midop_reset();
        run_table("rst_fill", '{{1'b1, 32'h11112223, 1'b0, 1'b0, 1'b0},
                                {1'b1, 32'h33334445, 1'b0, 1'b0, 1'b0}});
        @(negedge clk);
        fetch_valid = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        n_cmp++;
        if ({fetch_ready, i0_valid, i0_is_c, i0_instr} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL midop_reset got=%h expected=%h",
                     {fetch_ready, i0_valid, i0_is_c, i0_instr}, {1'b1, 1'b0, 1'b0, 32'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        run_table("rst_after", '{{1'b1, 32'h00A00093, 1'b0, 1'b1, 1'b0},
                                 {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}});
    endtask

    task automatic test_random();
        logic [35:0] tbl[$];
        for (int i = 0; i < 600; i++) begin
            tbl.push_back({($urandom_range(0, 3) != 0), $urandom(), $urandom_range(0, 1) == 1,
                           ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0)});
        end
        run_table("random", tbl);
    endtask

    initial begin
        test_reset();
        test_compressed_pair();
        test_full_word();
        test_split();
        test_backpressure();
        test_flush();
        test_midop_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/el2_ifu_halfword_aligner.md
EL2_IFU_HALFWORD_ALIGNER -- requirements
Module: el2_ifu_halfword_aligner

Interface
REQ-001 SHALL have port: clk  input  1  core clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: flush  input  1  discard all buffered halfwords.
REQ-004 SHALL have port: fetch_valid  input  1  fetch word offered.
REQ-005 SHALL have port: fetch_data  input  32  fetch word; halfword0 = [15:0], halfword1 = [31:16].
REQ-006 SHALL have port: fetch_hw_offset  input  1  1 = only halfword1 is valid (target is upper half).
REQ-007 SHALL have port: fetch_ready  output  1  space for two halfwords.
REQ-008 SHALL have port: i0_valid  output  1  complete instruction at head.
REQ-009 SHALL have port: i0_instr  output  32  raw instruction; compressed value zero-extended in [31:16].
REQ-010 SHALL have port: i0_is_c  output  1  head is 16-bit (head halfword [1:0] != 2'b11); [15:0] feeds the decompressor.
REQ-011 SHALL have port: i0_ready  input  1  downstream consumes head.

Function
REQ-012 SHALL hold a 4-entry halfword FIFO with a 3-bit count (0..4), read pointer and write pointer, each 2-bit and wrapping modulo 4.
REQ-013 SHALL drive fetch_ready = (count <= 2) and deassert it during flush.
REQ-014 SHALL push on fetch_valid & fetch_ready & !flush: two halfwords (halfword0 then halfword1) when fetch_hw_offset=0, only halfword1 when 1.
REQ-015 SHALL compute i0_valid combinationally from registered state: (count>=1 & head is 16-bit) | (count>=2 & head is 32-bit); a pushed word is visible no earlier than the next cycle (no bypass).
REQ-016 SHALL form a 32-bit instruction as {entry[rptr+1], entry[rptr]}.
REQ-017 SHALL pop on i0_valid & i0_ready: 1 halfword if i0_is_c, else 2.
REQ-018 SHALL support push and pop in the same cycle; next count = count + pushed - popped, never exceeding 4 or going below 0.
REQ-019 SHALL keep i0_instr and i0_is_c stable while i0_valid & !i0_ready.
REQ-020 SHALL drive i0_instr, i0_is_c = 0 whenever i0_valid = 0.
REQ-021 SHALL, when the head is 32-bit and count = 1, hold i0_valid = 0 until the next halfword arrives (split instruction across fetch words).
REQ-022 SHALL, on flush, set count and both pointers to 0 at the next edge; flush dominates a simultaneous push and pop; i0_valid is forced 0 in the flush cycle.

Reset
REQ-023 SHALL, while rst = 1, clear count and pointers asynchronously: fetch_ready = 1, i0_valid = 0, i0_instr = 0, i0_is_c = 0.
REQ-024 SHALL leave FIFO data storage unreset; it is never observable while count = 0.
REQ-025 SHALL treat a reset assertion mid-operation like flush; in-flight instructions are lost and nothing is popped.

Configuration
REQ-026 SHALL gate compressed support with macro RV_ALIGN_COMPRESSED_EN.
REQ-027 With RV_ALIGN_COMPRESSED_EN defined: behaviour as REQ-010 to REQ-021.
REQ-028 Without the macro:
- i0_is_c tied 0.
- Every head is treated as 32-bit, so pops are always 2 halfwords.
- fetch_hw_offset is ignored and both halfwords are pushed.

Verification
REQ-029 Reset, then fetch 0x00130001 (offset 0) -> next cycle: i0_valid=1, i0_is_c=1, i0_instr=0x00000001; after a pop: i0_is_c=0, count=1, i0_valid=0.
REQ-030 Fetch 0x00A00093 with i0_ready=1 -> one cycle later: i0_instr=0x00A00093, i0_is_c=0; count returns to 0.
REQ-031 Split instruction: fetch 0x00934501 then 0x12340013 -> outputs 0x00004501 (c), then 0x00130093 (32-bit), then 0x00001234 (c).
REQ-032 i0_ready=0 with 3 fetches offered -> fetch_ready drops after count reaches 4; the third word is not accepted; no halfword is lost or duplicated.
REQ-033 Flush asserted with fetch_valid=1 and count=3 -> next cycle: count=0, i0_valid=0; the flush-cycle fetch word is dropped.
REQ-034 With the macro undefined, fetch 0x00010001 -> i0_instr=0x00010001, i0_is_c=0, pop of 2 halfwords.
